// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module : rtc_pkg
// Desc   : Register map, bus FSM encoding and BCD helpers for the RTC responder.
// Rev    : 1.0  initial release
// ============================================================================
package rtc_pkg;

  localparam logic [7:0] c_addr_status = 8'h02;
  localparam logic [7:0] c_addr_sec    = 8'h21;
  localparam logic [7:0] c_addr_min    = 8'h22;
  localparam logic [7:0] c_addr_hour   = 8'h23;
  localparam logic [7:0] c_addr_day    = 8'h24;
  localparam logic [7:0] c_addr_month  = 8'h25;
  localparam logic [7:0] c_addr_year   = 8'h26;
  localparam logic [7:0] c_addr_tsec   = 8'h41;
  localparam logic [7:0] c_addr_tmin   = 8'h42;
  localparam logic [7:0] c_addr_thour  = 8'h43;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR_PH = 2'd1,
    ST_DATA_WR = 2'd2,
    ST_DATA_RD = 2'd3
  } rtc_state_t;

  typedef struct packed {
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hour;
    logic [7:0] day;
    logic [7:0] month;
    logic [7:0] year;
    logic [7:0] tsec;
    logic [7:0] tmin;
    logic [7:0] thour;
  } rtc_regs_t;

  // Returns {carry, next}; values at or beyond vmax wrap to vmin.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax,
                                         input logic [7:0] vmin);
    logic [8:0] r;
    if (v >= vmax)           r = {1'b1, vmin};
    else if (v[3:0] >= 4'd9) r = {1'b0, v[7:4] + 4'd1, 4'h0};
    else                     r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Returns {borrow, next}; zero wraps to vmax.
  function automatic logic [8:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
    logic [8:0] r;
    if (v == 8'h00)          r = {1'b1, vmax};
    else if (v[3:0] == 4'd0) r = {1'b0, v[7:4] - 4'd1, 4'h9};
    else                     r = {1'b0, v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_days_in_month(input logic [7:0] month,
                                                   input logic [7:0] year);
    logic       leap;
    logic [7:0] r;
    // 10*t+u is a multiple of 4 when u mod 4 equals 2 for odd t, 0 for even t.
    leap = (year[1:0] == {year[4], 1'b0});
    case (month)
      8'h02:                      r = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
      default:                    r = 8'h31;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_bus_responder_if.sv
`default_nettype none
// ============================================================================
// Module : rtc_bus_responder_if
// Desc   : Multiplexed active-low RTC bus between controller and responder.
// Rev    : 1.0  initial release
// ============================================================================
interface rtc_bus_responder_if;
  logic       CS;
  logic       RD;
  logic       WR;
  logic       A_D;
  logic [7:0] dir_dato_in;
  logic [7:0] dir_dato_out;
  logic       dir_dato_oe;

  modport slave  (input  CS, RD, WR, A_D, dir_dato_in,
                  output dir_dato_out, dir_dato_oe);
  modport master (output CS, RD, WR, A_D, dir_dato_in,
                  input  dir_dato_out, dir_dato_oe);
endinterface
`default_nettype wire

// File: rtl/rtc_bcd_timekeeper.sv
`default_nettype none
// ============================================================================
// Module : rtc_bcd_timekeeper
// Desc   : Next-state logic for BCD clock/calendar and countdown timer on tick.
//          Present only when RTC_TIMEKEEP_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`ifdef RTC_TIMEKEEP_EN
module rtc_bcd_timekeeper
  import rtc_pkg::*;
(
  input  logic      i_tick,
  input  rtc_regs_t i_cur,
  output rtc_regs_t o_next,
  output logic      o_expire
);

  logic [8:0] w_sec, w_min, w_hour, w_day, w_month, w_tsec, w_tmin;
  logic [7:0] w_year, w_thour;
  logic       w_unused_yc, w_unused_hb;
  logic       w_timer_run;

  assign w_sec   = bcd_inc(i_cur.sec,   8'h59, 8'h00);
  assign w_min   = bcd_inc(i_cur.min,   8'h59, 8'h00);
  assign w_hour  = bcd_inc(i_cur.hour,  8'h23, 8'h00);
  assign w_day   = bcd_inc(i_cur.day,   bcd_days_in_month(i_cur.month, i_cur.year), 8'h01);
  assign w_month = bcd_inc(i_cur.month, 8'h12, 8'h01);
  assign {w_unused_yc, w_year}  = bcd_inc(i_cur.year, 8'h99, 8'h00);
  assign w_tsec  = bcd_dec(i_cur.tsec,  8'h59);
  assign w_tmin  = bcd_dec(i_cur.tmin,  8'h59);
  assign {w_unused_hb, w_thour} = bcd_dec(i_cur.thour, 8'h23);
  assign w_timer_run = (i_cur.tsec != 8'h00) || (i_cur.tmin != 8'h00) || (i_cur.thour != 8'h00);

  always_comb begin
    o_next   = i_cur;
    o_expire = 1'b0;
    if (i_tick) begin
      o_next.sec = w_sec[7:0];
      if (w_sec[8]) begin
        o_next.min = w_min[7:0];
        if (w_min[8]) begin
          o_next.hour = w_hour[7:0];
          if (w_hour[8]) begin
            o_next.day = w_day[7:0];
            if (w_day[8]) begin
              o_next.month = w_month[7:0];
              if (w_month[8]) o_next.year = w_year;
            end
          end
        end
      end
      if (w_timer_run) begin
        o_next.tsec = w_tsec[7:0];
        if (w_tsec[8]) begin
          o_next.tmin = w_tmin[7:0];
          if (w_tmin[8]) o_next.thour = w_thour;
        end
        o_expire = (o_next.tsec == 8'h00) && (o_next.tmin == 8'h00) && (o_next.thour == 8'h00);
      end
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/rtc_bus_responder.sv
`default_nettype none
// ============================================================================
// Module : rtc_bus_responder
// Desc   : Device-side multiplexed-bus RTC: bus FSM, BCD register file, timer.
//          Tick-driven timekeeping enabled by macro RTC_TIMEKEEP_EN.
// Rev    : 1.0  initial release
// ============================================================================
module rtc_bus_responder
  import rtc_pkg::*;
#(
  parameter logic [7:0] INIT_DAY   = 8'h01,
  parameter logic [7:0] INIT_MONTH = 8'h01,
  parameter logic [7:0] INIT_YEAR  = 8'h00
) (
  input  logic                reloj,
  input  logic                resetM,
  input  logic                tick_1hz,
  output logic                irq,
  rtc_bus_responder_if.slave  bus
);

  rtc_state_t r_state;
  logic [7:0] r_addr, r_shadow, r_dout;
  logic       r_oe, r_timer_done;
  rtc_regs_t  r_regs, w_tk_next;
  logic       w_tk_expire;
  logic       w_sel, w_rd, w_wr, w_wr_commit;
  logic [7:0] w_rd_data;

  assign w_sel = !bus.CS;
  assign w_rd  = !bus.RD;
  assign w_wr  = !bus.WR;
  assign w_wr_commit = (r_state == ST_DATA_WR) && w_sel && !w_wr;

  assign bus.dir_dato_out = r_dout;
  assign bus.dir_dato_oe  = r_oe;
  assign irq              = r_timer_done;

`ifdef RTC_TIMEKEEP_EN
  rtc_bcd_timekeeper u_timekeeper (
    .i_tick   (tick_1hz),
    .i_cur    (r_regs),
    .o_next   (w_tk_next),
    .o_expire (w_tk_expire)
  );
`else
  logic w_unused_tick;
  assign w_unused_tick = tick_1hz;
  assign w_tk_next     = r_regs;
  assign w_tk_expire   = 1'b0;
`endif

  always_comb begin
    w_rd_data = 8'h00;
    case (r_addr)
      c_addr_status: w_rd_data = {7'd0, r_timer_done};
      c_addr_sec:    w_rd_data = r_regs.sec;
      c_addr_min:    w_rd_data = r_regs.min;
      c_addr_hour:   w_rd_data = r_regs.hour;
      c_addr_day:    w_rd_data = r_regs.day;
      c_addr_month:  w_rd_data = r_regs.month;
      c_addr_year:   w_rd_data = r_regs.year;
      c_addr_tsec:   w_rd_data = r_regs.tsec;
      c_addr_tmin:   w_rd_data = r_regs.tmin;
      c_addr_thour:  w_rd_data = r_regs.thour;
      default:       w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_state  <= ST_IDLE;
      r_addr   <= 8'h00;
      r_shadow <= 8'h00;
      r_oe     <= 1'b0;
      r_dout   <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel && w_wr && !w_rd) begin
            r_shadow <= bus.dir_dato_in;
            r_state  <= bus.A_D ? ST_DATA_WR : ST_ADDR_PH;
          end else if (w_sel && w_rd && !w_wr && bus.A_D) begin
            r_state <= ST_DATA_RD;
            r_oe    <= 1'b1;
            r_dout  <= w_rd_data;
          end
        end
        ST_ADDR_PH: begin
          if (!w_sel || (w_wr && w_rd)) begin
            r_state <= ST_IDLE;
          end else if (w_wr) begin
            r_shadow <= bus.dir_dato_in;
          end else begin
            r_addr  <= r_shadow;
            r_state <= ST_IDLE;
          end
        end
        ST_DATA_WR: begin
          // The register write itself happens in the register-file block on w_wr_commit.
          if (!w_sel || (w_wr && w_rd) || !w_wr) begin
            r_state <= ST_IDLE;
          end else begin
            r_shadow <= bus.dir_dato_in;
          end
        end
        ST_DATA_RD: begin
          if (!w_sel || !w_rd || w_wr) begin
            r_state <= ST_IDLE;
            r_oe    <= 1'b0;
            r_dout  <= 8'h00;
          end else begin
            r_dout <= w_rd_data;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Tick update first, bus write afterwards so it wins on the same register.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_regs <= '{sec: 8'h00, min: 8'h00, hour: 8'h00,
                  day: INIT_DAY, month: INIT_MONTH, year: INIT_YEAR,
                  tsec: 8'h00, tmin: 8'h00, thour: 8'h00};
      r_timer_done <= 1'b0;
    end else begin
      r_regs <= w_tk_next;
      if (w_tk_expire) r_timer_done <= 1'b1;
      if (w_wr_commit) begin
        case (r_addr)
          c_addr_status: if (!r_shadow[0]) r_timer_done <= 1'b0;
          c_addr_sec:    r_regs.sec   <= r_shadow;
          c_addr_min:    r_regs.min   <= r_shadow;
          c_addr_hour:   r_regs.hour  <= r_shadow;
          c_addr_day:    r_regs.day   <= r_shadow;
          c_addr_month:  r_regs.month <= r_shadow;
          c_addr_year:   r_regs.year  <= r_shadow;
          c_addr_tsec:   r_regs.tsec  <= r_shadow;
          c_addr_tmin:   r_regs.tmin  <= r_shadow;
          c_addr_thour:  r_regs.thour <= r_shadow;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_rtc_bus_responder
// Desc   : Directed bus transactions; read data checked by a queue-fed monitor.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rtc_bus_responder;

  logic reloj    = 1'b0;
  logic resetM   = 1'b1;
  logic tick_1hz = 1'b0;
  logic irq;

  rtc_bus_responder_if bus_if();

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] held    = 8'h00;
  logic       prev_oe = 1'b0;

  always #5 reloj = ~reloj;

  rtc_bus_responder #(
    .INIT_DAY   (8'h01),
    .INIT_MONTH (8'h01),
    .INIT_YEAR  (8'h00)
  ) dut (
    .reloj    (reloj),
    .resetM   (resetM),
    .tick_1hz (tick_1hz),
    .irq      (irq),
    .bus      (bus_if)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: a rising oe pops the next expected read value, held for the whole strobe.
  always @(negedge reloj) begin
    if (!resetM && bus_if.dir_dato_oe) begin
      if (!prev_oe) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got=%h want=none", bus_if.dir_dato_out);
          held = bus_if.dir_dato_out;
        end else begin
          held = exp_q.pop_front();
        end
      end
      chk("rd_data", bus_if.dir_dato_out, held);
    end
    prev_oe = bus_if.dir_dato_oe;
  end

  task automatic step();
    @(posedge reloj);
    #1;
  endtask

  task automatic bus_idle();
    bus_if.CS = 1'b1; bus_if.RD = 1'b1; bus_if.WR = 1'b1;
    bus_if.A_D = 1'b0; bus_if.dir_dato_in = 8'h00;
  endtask

  task automatic addr_phase(input logic [7:0] a);
    bus_if.CS = 1'b0; bus_if.A_D = 1'b0; bus_if.WR = 1'b0; bus_if.dir_dato_in = a;
    step(); step();
    bus_if.WR = 1'b1;
    step();
    bus_idle();
    step();
  endtask

  task automatic write_phase(input logic [7:0] d);
    bus_if.CS = 1'b0; bus_if.A_D = 1'b1; bus_if.WR = 1'b0; bus_if.dir_dato_in = d;
    step(); chk("wr_oe", {7'd0, bus_if.dir_dato_oe}, 8'h00);
    step(); chk("wr_oe", {7'd0, bus_if.dir_dato_oe}, 8'h00);
    bus_if.WR = 1'b1;
    step(); chk("wr_oe", {7'd0, bus_if.dir_dato_oe}, 8'h00);
    bus_idle();
    step();
  endtask

  task automatic read_phase(input int n, input logic [7:0] exp);
    exp_q.push_back(exp);
    chk("oe_pre", {7'd0, bus_if.dir_dato_oe}, 8'h00);
    bus_if.CS = 1'b0; bus_if.A_D = 1'b1; bus_if.RD = 1'b0;
    step(); chk("oe_rise", {7'd0, bus_if.dir_dato_oe}, 8'h01);
    for (int i = 1; i < n; i++) step();
    bus_if.RD = 1'b1;
    step(); chk("oe_fall", {7'd0, bus_if.dir_dato_oe}, 8'h00);
    bus_idle();
    step();
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    addr_phase(a);
    write_phase(d);
  endtask

  task automatic rd_reg(input logic [7:0] a, input logic [7:0] exp);
    addr_phase(a);
    read_phase(2, exp);
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_idle();
    resetM = 1'b1;
    repeat (3) step();
    chk("rst_oe",   {7'd0, bus_if.dir_dato_oe}, 8'h00);
    chk("rst_dout", bus_if.dir_dato_out, 8'h00);
    chk("rst_irq",  {7'd0, irq}, 8'h00);
    resetM = 1'b0;
    step();

    wr_reg(8'h22, 8'h45);
    rd_reg(8'h22, 8'h45);

    addr_phase(8'h24);
    read_phase(7, 8'h01);
    rd_reg(8'h25, 8'h01);
    rd_reg(8'h26, 8'h00);

    // Data phases reuse the latched address.
    write_phase(8'h23);
    read_phase(2, 8'h23);

    // Address phase aborted by CS rising while WR is still low.
    addr_phase(8'h22);
    bus_if.CS = 1'b0; bus_if.A_D = 1'b0; bus_if.WR = 1'b0; bus_if.dir_dato_in = 8'h41;
    step();
    bus_if.CS = 1'b1;
    step();
    bus_idle();
    step();
    read_phase(2, 8'h45);

    // Write phase aborted the same way: no register change.
    bus_if.CS = 1'b0; bus_if.A_D = 1'b1; bus_if.WR = 1'b0; bus_if.dir_dato_in = 8'h99;
    step();
    bus_if.CS = 1'b1;
    step();
    bus_idle();
    step();
    read_phase(2, 8'h45);

    // RD and WR low together: protocol error, nothing happens.
    bus_if.CS = 1'b0; bus_if.RD = 1'b0; bus_if.WR = 1'b0;
    bus_if.A_D = 1'b0; bus_if.dir_dato_in = 8'h7F;
    step(); chk("err_oe", {7'd0, bus_if.dir_dato_oe}, 8'h00);
    bus_if.A_D = 1'b1; bus_if.dir_dato_in = 8'h77;
    step(); chk("err_oe", {7'd0, bus_if.dir_dato_oe}, 8'h00);
    step(); chk("err_oe", {7'd0, bus_if.dir_dato_oe}, 8'h00);
    bus_idle();
    step();
    read_phase(2, 8'h45);

    wr_reg(8'h7F, 8'h55);
    rd_reg(8'h7F, 8'h00);
    rd_reg(8'h02, 8'h00);
    chk("irq_idle", {7'd0, irq}, 8'h00);
    wr_reg(8'h41, 8'h12);
    rd_reg(8'h41, 8'h12);
    wr_reg(8'h43, 8'h23);
    rd_reg(8'h43, 8'h23);

`ifndef RTC_TIMEKEEP_EN
    repeat (3) pulse_tick();
    rd_reg(8'h21, 8'h00);
    rd_reg(8'h41, 8'h12);
    chk("irq_notk", {7'd0, irq}, 8'h00);
`endif

    // Reset in the middle of a read strobe.
    addr_phase(8'h22);
    exp_q.push_back(8'h45);
    bus_if.CS = 1'b0; bus_if.A_D = 1'b1; bus_if.RD = 1'b0;
    step(); step();
    resetM = 1'b1;
    step();
    chk("rstrd_oe",   {7'd0, bus_if.dir_dato_oe}, 8'h00);
    chk("rstrd_dout", bus_if.dir_dato_out, 8'h00);
    bus_idle();
    step();
    resetM = 1'b0;
    step();
    rd_reg(8'h22, 8'h00);
    rd_reg(8'h24, 8'h01);
    rd_reg(8'h26, 8'h00);
    rd_reg(8'h43, 8'h00);

`ifdef RTC_TIMEKEEP_EN
    wr_reg(8'h21, 8'h59); wr_reg(8'h22, 8'h59); wr_reg(8'h23, 8'h23);
    wr_reg(8'h24, 8'h28); wr_reg(8'h25, 8'h02); wr_reg(8'h26, 8'h23);
    pulse_tick();
    rd_reg(8'h21, 8'h00); rd_reg(8'h22, 8'h00); rd_reg(8'h23, 8'h00);
    rd_reg(8'h24, 8'h01); rd_reg(8'h25, 8'h03); rd_reg(8'h26, 8'h23);

    wr_reg(8'h21, 8'h59); wr_reg(8'h22, 8'h59); wr_reg(8'h23, 8'h23);
    wr_reg(8'h24, 8'h28); wr_reg(8'h25, 8'h02); wr_reg(8'h26, 8'h24);
    pulse_tick();
    rd_reg(8'h23, 8'h00); rd_reg(8'h24, 8'h29); rd_reg(8'h25, 8'h02);

    wr_reg(8'h41, 8'h02); wr_reg(8'h42, 8'h00); wr_reg(8'h43, 8'h00);
    pulse_tick();
    chk("irq_tick1", {7'd0, irq}, 8'h00);
    pulse_tick();
    chk("irq_tick2", {7'd0, irq}, 8'h01);
    rd_reg(8'h02, 8'h01);
    wr_reg(8'h02, 8'h00);
    chk("irq_clr", {7'd0, irq}, 8'h00);
    wr_reg(8'h02, 8'h01);
    chk("irq_w1", {7'd0, irq}, 8'h00);
    rd_reg(8'h41, 8'h00);
`endif

    step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rd_drain: got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
